spi_regfile_slave: RTL and testbench
====================================

# spi_regfile_slave

Parametrised SPI slave register file, the successor to the fixed 8-bit single-register SPI slave. An SPI master writes and reads a bank of `DEPTH` registers of `DATA_WIDTH` bits over MOSI/MISO, using a command word of one R/W bit plus an `ADDR_WIDTH`-bit address. The block supports all four SPI modes and auto-increment burst transfers. It sits on the system clock `CLK`; SCLK, CS and MOSI are treated as asynchronous inputs and oversampled.

## Interface
- `ADDR_WIDTH`, 7: address field width in the command word.
- `DATA_WIDTH`, 8: register and data-frame width.
- `DEPTH`, 128: number of implemented registers, at most 2^`ADDR_WIDTH`.
- `MODE`, 0: SPI mode 0–3; `CPOL = MODE[1]`, `CPHA = MODE[0]`.

Ports:
- `CLK`  in  1  system clock, at least 8× the SCLK frequency.
- `RST`  in  1  asynchronous, active-high reset.
- `SCLK`  in  1  SPI serial clock, asynchronous.
- `CS`  in  1  chip select, active low, asynchronous.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; 0 when not driving.
- `MISO_OE`  out  1  high while CS is low; for an external tri-state buffer.
- `WR_STB`  out  1  one-CLK pulse per committed register write.
- `WR_ADDR`  out  `ADDR_WIDTH`  address of the last committed write.
- `WR_DATA`  out  `DATA_WIDTH`  data of the last committed write.
- `RD_ADDR`  in  `ADDR_WIDTH`  local, combinational fabric read port address.
- `RD_DATA`  out  `DATA_WIDTH`  register at `RD_ADDR`; 0 if out of range.

## Operation
- **Synchronisers:** SCLK, CS and MOSI each pass through a 2-flop synchroniser plus one history flop. Edge pulses come from the history flop.
- **Edges:** leading edge is rising if CPOL=0, falling if CPOL=1. The sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. The shift edge is the other edge.
- **Frame:** starts at the synchronised CS falling edge. The bit counter and shift registers clear.
- **Command phase:** 1+`ADDR_WIDTH` sample edges. Bit 0 is R/W (0=write, 1=read), followed by the address MSB first.
- **State machine:** IDLE → CMD → DATA → DATA … → IDLE on CS high.
  - IDLE: MISO=0.
  - CMD: count command bits.
  - DATA: `DATA_WIDTH` sample edges per word.
- **Write:** on the last sample edge of a data word, if addr < `DEPTH`, the register is written. In the same CLK, `WR_STB`=1 and `WR_ADDR`/`WR_DATA` update. Writes to addr ≥ `DEPTH` are dropped with no strobe.
- **Read:** on the last command sample edge, the shift-out register loads reg[addr], or 0 if out of range. For CPHA=0, MISO presents the MSB within 3 CLK of that edge. For CPHA=1, MISO presents the MSB on the next shift edge. Each following shift edge advances one bit.
- **Burst:** after each data word, addr increments modulo `DEPTH` (`DEPTH`−1 → 0). Reads reload the next register at the word boundary; writes continue with the same R/W.
- **Abort:** CS rising mid-word discards the partial word, with no write and no strobe. The state returns to IDLE, and the next CS falling edge starts a new command.
- **Glitches:** edges while CS is high are ignored.
- **Reset:** `RST` asserted at any time, including mid-frame, clears all registers to 0 and sets the state to IDLE. Outputs reset to `MISO`=0, `MISO_OE`=0, `WR_STB`=0, `WR_ADDR`=0, `WR_DATA`=0.

## Timing
- Input-to-internal-edge latency is 3 CLK. SCLK high and low phases must each be at least 4 CLK.
- `WR_STB` asserts 3–4 CLK after the final external sample edge and lasts exactly 1 CLK.
- MISO changes only within 4 CLK after an external shift edge, or after the load edge for CPHA=0.
- `MISO_OE` follows synchronised CS with 2–3 CLK latency.
- `RD_DATA` is combinational from register state and `RD_ADDR`.
- Simultaneous `WR_STB` and an `RD_ADDR` match: `RD_DATA` shows the old value in that CLK and the new value from the next CLK.
- CS rising on the same CLK as a final sample edge: the word commits, because the sample edge takes priority.

## Test plan
- **Write then read back, MODE=0, defaults, SCLK=10×CLK:** send write 0_1010101 then 0x33. Then send read 1_1010101 and clock 8 bits. Required: `WR_STB` once with `WR_ADDR`=0x55, `WR_DATA`=0x33; MISO bits 0,0,1,1,0,0,1,1; `RD_DATA`@0x55=0x33.
- **Burst write with wrap:** write at addr 0x7F, data 0xA1, 0xB2, 0xC3. Required: reg[0x7F]=0xA1, reg[0x00]=0xB2, reg[0x01]=0xC3; 3 strobes.
- **Abort:** write at 0x10, raise CS after 5 data bits. Required: no `WR_STB`, reg[0x10] unchanged. The next frame, a read of 0x10, returns the old value.
- **Out of range, `DEPTH`=100:** write 0x5A to addr 0x70. Required: no strobe; read of 0x70 returns 0x00 on MISO.
- **Modes 1–3:** repeat the first scenario per mode with matching master timing. Required: identical register contents and MISO bit sequence.
- **Reset mid-frame:** pulse `RST` during bit 3 of a data word. Required: all outputs reset values immediately, all registers 0, and a following clean write/read works.

Source files
------------

// File: rtl/spi_regfile_slave.sv
// SPI slave register file: command word {R/W, address} then burst data words,
// with all four SPI modes and SCLK/CS/MOSI oversampled on the system clock.
//
// state | meaning
// IDLE  | CS high or frame ended; MISO held at 0, waiting for a CS falling edge
// CMD   | shifting in the R/W bit and address, MSB first
// DATA  | shifting data words; address auto-increments at every word boundary
module spi_regfile_slave #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int MODE       = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    output logic                  WR_STB,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic [DATA_WIDTH-1:0] RD_DATA
);

    localparam logic [1:0] MODE_L = 2'(MODE);
    localparam logic CPOL = MODE_L[1];
    localparam logic CPHA = MODE_L[0];
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0] sclk_sync_q, cs_sync_q, mosi_sync_q;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] cmd_q, cmd_d;
    logic [DATA_WIDTH-2:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic                  skip_q, skip_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  oe_q;
    logic                  wr_stb_q, wr_stb_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                  sample_edge, shift_edge;
    logic                  cs_fall, cs_rise, mosi_s;
    logic [DATA_WIDTH-1:0] word;
    logic [ADDR_WIDTH:0]   cmd_next;
    logic [ADDR_WIDTH-1:0] addr_next, load_addr;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_val;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    // Bit 1 is the synchronised level, bit 2 the history used for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sclk_sync_q <= {3{CPOL}};
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 3'b000;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
            cs_sync_q   <= {cs_sync_q[1:0], CS};
            mosi_sync_q <= {mosi_sync_q[1:0], MOSI};
        end
    end

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    assign mosi_s      = mosi_sync_q[2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        skip_d    = skip_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        load      = 1'b0;
        load_addr = addr_q;
        word      = {rx_q, mosi_s};
        cmd_next  = {cmd_q, mosi_s};
        addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    cnt_d   = CW'(ADDR_WIDTH);
                    cmd_d   = '0;
                    rx_d    = '0;
                    tx_d    = '0;
                    miso_d  = 1'b0;
                    skip_d  = 1'b0;
                end
            end
            CMD: begin
                if (sample_edge) begin
                    cmd_d = cmd_next[ADDR_WIDTH-1:0];
                    if (cnt_q == '0) begin
                        rw_d      = cmd_next[ADDR_WIDTH];
                        addr_d    = cmd_next[ADDR_WIDTH-1:0];
                        cnt_d     = CW'(DATA_WIDTH - 1);
                        state_d   = DATA;
                        load      = cmd_next[ADDR_WIDTH];
                        load_addr = cmd_next[ADDR_WIDTH-1:0];
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_edge) begin
                    rx_d = word[DATA_WIDTH-2:0];
                    if (cnt_q == '0) begin
                        if (!rw_q && in_range(addr_q)) begin
                            wr_stb_d  = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = word;
                        end
                        addr_d    = addr_next;
                        cnt_d     = CW'(DATA_WIDTH - 1);
                        load      = rw_q;
                        load_addr = addr_next;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        load_val = in_range(load_addr) ? mem_q[load_addr] : '0;

        // CPHA=0 drives the MSB at load time, so the shift edge that closes the
        // load bit must not advance the word.
        if (load) begin
            if (CPHA) begin
                tx_d   = load_val;
                skip_d = 1'b0;
            end else begin
                tx_d   = load_val << 1;
                miso_d = load_val[DATA_WIDTH-1];
                skip_d = 1'b1;
            end
        end else if (shift_edge && state_q != IDLE) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                miso_d = tx_q[DATA_WIDTH-1];
                tx_d   = tx_q << 1;
            end
        end

        // Evaluated after the sample edge so a final bit coinciding with CS rising still commits.
        if (state_q != IDLE && cs_rise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            skip_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            skip_q    <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            oe_q      <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            skip_q    <= skip_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            oe_q      <= ~cs_sync_q[1];
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // The array updates one CLK after the strobe so RD_DATA shows the old value during WR_STB.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_stb_q) begin
            mem_q[wr_addr_q] <= wr_data_q;
        end
    end

    assign MISO    = miso_q;
    assign MISO_OE = oe_q;
    assign WR_STB  = wr_stb_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;
    assign RD_DATA = in_range(RD_ADDR) ? mem_q[RD_ADDR] : '0;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed bench: instances 0-3 run SPI modes 0-3 with DEPTH=128, instance 4
// runs mode 0 with DEPTH=100 for the out-of-range cases.
`timescale 1ns/1ps
module tb_spi_regfile_slave;

    logic       clk;
    logic       rst;
    logic       sclk    [5];
    logic       cs      [5];
    logic       mosi    [5];
    logic       miso    [5];
    logic       oe      [5];
    logic       stb     [5];
    logic [6:0] wr_addr [5];
    logic [7:0] wr_data [5];
    logic [6:0] rd_addr [5];
    logic [7:0] rd_data [5];

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt [5];
    int s0;
    logic [63:0] rx;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        spi_regfile_slave #(
            .ADDR_WIDTH(7),
            .DATA_WIDTH(8),
            .DEPTH     ((g == 4) ? 100 : 128),
            .MODE      ((g == 4) ? 0 : g)
        ) u_dut (
            .CLK    (clk),
            .RST    (rst),
            .SCLK   (sclk[g]),
            .CS     (cs[g]),
            .MOSI   (mosi[g]),
            .MISO   (miso[g]),
            .MISO_OE(oe[g]),
            .WR_STB (stb[g]),
            .WR_ADDR(wr_addr[g]),
            .WR_DATA(wr_data[g]),
            .RD_ADDR(rd_addr[g]),
            .RD_DATA(rd_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 5; i++) stb_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (stb[i] === 1'b1) stb_cnt[i]++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input int d, input logic [6:0] a, input logic [7:0] exp);
        rd_addr[d] = a;
        #1;
        check_val(tag, {24'h0, rd_data[d]}, {24'h0, exp});
    endtask

    // Sends tx[nbits-1] first; rx collects MISO at every master sample edge.
    task automatic spi_frame(input int d, input logic [63:0] tx, input int nbits,
                             output logic [63:0] rx_o);
        logic cpol, cpha;
        cpol = (d == 2 || d == 3);
        cpha = (d == 1 || d == 3);
        rx_o = '0;
        cs[d] = 1'b0;
        clk_wait(6);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[d] = tx[nbits-1-i];
                clk_wait(5);
                sclk[d] = ~cpol;
                rx_o = {rx_o[62:0], miso[d]};
                clk_wait(5);
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = tx[nbits-1-i];
                clk_wait(5);
                sclk[d] = cpol;
                rx_o = {rx_o[62:0], miso[d]};
                clk_wait(5);
            end
        end
        clk_wait(5);
        cs[d]   = 1'b1;
        mosi[d] = 1'b0;
        clk_wait(10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sclk[i]    = (i == 2 || i == 3);
            cs[i]      = 1'b1;
            mosi[i]    = 1'b0;
            rd_addr[i] = 7'h00;
        end
        clk_wait(4);
        check_val("rst_miso", {31'h0, miso[0]}, 32'h0);
        check_val("rst_oe", {31'h0, oe[0]}, 32'h0);
        check_val("rst_stb", {31'h0, stb[0]}, 32'h0);
        check_val("rst_wr_addr", {25'h0, wr_addr[0]}, 32'h0);
        check_val("rst_wr_data", {24'h0, wr_data[0]}, 32'h0);
        rst = 1'b0;
        clk_wait(4);
        rd_chk("rst_rd_data", 0, 7'h55, 8'h00);

        // Write 0x33 to 0x55, then read it back over MISO, in every mode.
        for (int d = 0; d < 4; d++) begin
            s0 = stb_cnt[d];
            spi_frame(d, 64'h5533, 16, rx);
            check_val($sformatf("m%0d_wr_stb_cnt", d), stb_cnt[d] - s0, 1);
            check_val($sformatf("m%0d_wr_addr", d), {25'h0, wr_addr[d]}, 32'h55);
            check_val($sformatf("m%0d_wr_data", d), {24'h0, wr_data[d]}, 32'h33);
            rd_chk($sformatf("m%0d_rd_data", d), d, 7'h55, 8'h33);
            spi_frame(d, 64'hD500, 16, rx);
            check_val($sformatf("m%0d_miso_bits", d), {24'h0, rx[7:0]}, 32'h33);
            check_val($sformatf("m%0d_oe_idle", d), {31'h0, oe[d]}, 32'h0);
        end

        // Burst write across the top of the array, then burst read it back.
        s0 = stb_cnt[0];
        spi_frame(0, 64'h7FA1B2C3, 32, rx);
        check_val("burst_stb_cnt", stb_cnt[0] - s0, 3);
        rd_chk("burst_7f", 0, 7'h7F, 8'hA1);
        rd_chk("burst_00", 0, 7'h00, 8'hB2);
        rd_chk("burst_01", 0, 7'h01, 8'hC3);
        spi_frame(0, 64'hFF000000, 32, rx);
        check_val("burst_read", {8'h0, rx[23:0]}, 32'hA1B2C3);

        // Abort: a partial word after a known value must leave it untouched.
        spi_frame(0, 64'h105C, 16, rx);
        rd_chk("abort_pre", 0, 7'h10, 8'h5C);
        s0 = stb_cnt[0];
        spi_frame(0, {51'h0, 8'h10, 5'b10101}, 13, rx);
        check_val("abort_no_stb", stb_cnt[0] - s0, 0);
        rd_chk("abort_reg", 0, 7'h10, 8'h5C);
        spi_frame(0, 64'h9000, 16, rx);
        check_val("abort_readback", {24'h0, rx[7:0]}, 32'h5C);

        // DEPTH=100: addr 0x70 is out of range.
        s0 = stb_cnt[4];
        spi_frame(4, 64'h705A, 16, rx);
        check_val("oor_no_stb", stb_cnt[4] - s0, 0);
        rd_chk("oor_rd_data", 4, 7'h70, 8'h00);
        spi_frame(4, 64'hF000, 16, rx);
        check_val("oor_miso", {24'h0, rx[7:0]}, 32'h00);
        spi_frame(4, 64'h635A, 16, rx);
        check_val("oor_last_ok", stb_cnt[4] - s0, 1);
        rd_chk("oor_last_reg", 4, 7'h63, 8'h5A);

        // Reset during data bit 3 of a write to instance 0.
        s0 = stb_cnt[0];
        fork
            spi_frame(0, 64'h55F0, 16, rx);
            begin
                clk_wait(117);
                check_val("mid_oe_active", {31'h0, oe[0]}, 32'h1);
                rst = 1'b1;
                #1;
                check_val("mid_rst_miso", {31'h0, miso[0]}, 32'h0);
                check_val("mid_rst_oe", {31'h0, oe[0]}, 32'h0);
                check_val("mid_rst_stb", {31'h0, stb[0]}, 32'h0);
                check_val("mid_rst_wr_addr", {25'h0, wr_addr[0]}, 32'h0);
                check_val("mid_rst_wr_data", {24'h0, wr_data[0]}, 32'h0);
                rd_chk("mid_rst_reg55", 0, 7'h55, 8'h00);
                rd_chk("mid_rst_reg10", 0, 7'h10, 8'h00);
                clk_wait(3);
                rst = 1'b0;
            end
        join
        check_val("mid_rst_no_stb", stb_cnt[0] - s0, 0);
        spi_frame(0, 64'h229E, 16, rx);
        check_val("post_rst_stb", stb_cnt[0] - s0, 1);
        check_val("post_rst_wr_data", {24'h0, wr_data[0]}, 32'h9E);
        rd_chk("post_rst_reg", 0, 7'h22, 8'h9E);
        spi_frame(0, 64'hA200, 16, rx);
        check_val("post_rst_miso", {24'h0, rx[7:0]}, 32'h9E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
